b11_driver: RTL and testbench
=============================

B11_DRIVER -- requirements
Module: b11_driver

Interface
REQ-001 Parameter STARTUP_CYCLES, default 2: idle cycles after reset before the first accept; legal range 2..15.
REQ-002 Parameter SETTLE_CYCLES, default 40: cycles waited after the strobe before sampling the result; legal range 12..255.
REQ-003 clock  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_in  input  6  upstream word to send.
REQ-006 data_valid  input  1  upstream word present.
REQ-007 data_ready  output  1  driver accepts data_in this cycle.
REQ-008 x_in  output  6  word presented to the scrambler's x_in port.
REQ-009 stbi  output  1  strobe to the scrambler; 1 = hold/wait, 0 = capture.
REQ-010 x_out  input  6  scrambler result port.
REQ-011 result  output  6  last sampled scrambler result.
REQ-012 result_valid  output  1  one-cycle pulse; result is new.
REQ-013 busy  output  1  transaction in progress (STROBE or WAIT).
REQ-014 txn_count  output  8  completed transactions, mod 256.

Function
REQ-015 The FSM SHALL have the states INIT, IDLE, STROBE, WAIT and REPORT; every output SHALL be registered.
REQ-016 INIT: stbi=1, data_ready=0; count STARTUP_CYCLES cycles, then go to IDLE.
REQ-017 IDLE: stbi=1, data_ready=1; on data_valid&data_ready, latch data_in into x_in and go to STROBE.
REQ-018 STROBE: stbi=0 for exactly one cycle with x_in stable; next state WAIT.
REQ-019 WAIT: stbi=1, x_in held; a counter loaded with SETTLE_CYCLES-1 decrements to 0, then go to REPORT.
REQ-020 REPORT: result<=x_out sampled this edge, result_valid=1 for one cycle, txn_count+1 (255 wraps to 0); next state IDLE.
REQ-021 x_in SHALL change only on the IDLE->STROBE edge; stbi SHALL never be 0 outside STROBE.
REQ-022 data_ready SHALL be 0 in every state except IDLE; data_valid outside IDLE is ignored, not dropped, because upstream holds it.
REQ-023 Captured words above 0x1A cause no scrambler output update; the driver SHALL still complete the transaction and report the unchanged x_out.
REQ-024 Back-to-back transfers: minimum spacing 3+SETTLE_CYCLES cycles between accepts.

Reset
REQ-025 reset SHALL override every state at the next edge: state=INIT; x_in=0, stbi=1, data_ready=0, result=0, result_valid=0, busy=0, txn_count=0; counters cleared.
REQ-026 A reset during STROBE or WAIT SHALL abort the transaction with no result_valid pulse and no txn_count increment.

Structure
REQ-027 A shared package b11_pkg SHALL hold the FSM state enum, the width constant (6) and the x_in acceptance limit 0x1A.
REQ-028 One sub-module b11_delay_counter (loadable down-counter with zero flag) SHALL be used for both the INIT and WAIT timing.

Verification
REQ-029 Reset for 3 cycles, then release -> stbi=1, x_in=0, data_ready=0 for 2 cycles, then data_ready=1.
REQ-030 Send 0x3F with a scrambler attached -> one cycle with stbi=0 and x_in=0x3F, then after 40 cycles result=0x3F, result_valid for 1 cycle, txn_count=1.
REQ-031 Send 0x00, then 0x1B -> results 0x00, then 0x00 again (no scrambler update), txn_count=2.
REQ-032 Hold data_valid=1 continuously with the values 0x05, 0x0A -> data_ready pulses exactly once per transaction; the accepts are 43 cycles apart.
REQ-033 Assert reset at WAIT cycle 10 -> no result_valid pulse, txn_count stays 0, INIT repeats.
REQ-034 Complete 256 transactions -> txn_count wraps to 0; assertion: stbi=0 never lasts more than 1 cycle.

Source files
------------

// File: rtl/b11_pkg.sv
// Shared constants and FSM state type for the b11 scrambler driver.
// The acceptance limit mirrors the scrambler: it only updates x_out for words up to this value.
package b11_pkg;

   localparam int unsigned B11_W     = 6;
   localparam int unsigned B11_CNT_W = 8;

   localparam logic [B11_W-1:0] B11_X_IN_LIMIT = 6'h1A;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_STROBE = 3'd2,
      ST_WAIT   = 3'd3,
      ST_REPORT = 3'd4
   } b11_state_e;

   // True when the scrambler is expected to act on this word.
   function automatic logic b11_in_range(input logic [B11_W-1:0] x);
      return (x <= B11_X_IN_LIMIT);
   endfunction

endpackage

// File: rtl/b11_delay_counter.sv
// Loadable down-counter with a zero flag; used for both the start-up and the settle delay.
// Load has priority; otherwise the count decrements and holds at zero.
module b11_delay_counter
   import b11_pkg::*;
#(
   parameter int unsigned W = B11_CNT_W
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic         o_zero_c
);

   logic [W-1:0] r_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (r_count != '0) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/b11_driver.sv
// Drives one word at a time into the scrambler: strobe it in, wait for it to settle,
// then sample and report x_out. All outputs come straight from registers.
module b11_driver
   import b11_pkg::*;
#(
   parameter int unsigned STARTUP_CYCLES = 2,
   parameter int unsigned SETTLE_CYCLES  = 40
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [B11_W-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic [B11_W-1:0] x_in,
   output logic             stbi,
   input  logic [B11_W-1:0] x_out,
   output logic [B11_W-1:0] result,
   output logic             result_valid,
   output logic             busy,
   output logic [7:0]       txn_count
);

   localparam int unsigned CNT_W = B11_CNT_W;

   b11_state_e       r_state;
   b11_state_e       w_state_nxt;
   logic             r_init_armed;
   logic [B11_W-1:0] r_x_in;
   logic             r_stbi;
   logic             r_data_ready;
   logic [B11_W-1:0] r_result;
   logic             r_result_valid;
   logic             r_busy;
   logic [7:0]       r_txn_count;

   logic             w_cnt_load;
   logic [CNT_W-1:0] w_cnt_value;
   logic             w_cnt_zero_c;
   logic             w_capture;
   logic             w_report;
   logic             w_stbi_nxt;
   logic             w_ready_nxt;
   logic             w_busy_nxt;

   b11_delay_counter #(
      .W (CNT_W)
   ) u_delay (
      .clock    (clock),
      .reset    (reset),
      .i_load   (w_cnt_load),
      .i_value  (w_cnt_value),
      .o_zero_c (w_cnt_zero_c)
   );

   // Next-state and next-output decode; INIT loads the counter on its first cycle only.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_load  = 1'b0;
      w_cnt_value = '0;
      w_capture   = 1'b0;
      w_report    = 1'b0;

      case (r_state)
         ST_INIT: begin
            if (!r_init_armed) begin
               w_cnt_load  = 1'b1;
               w_cnt_value = CNT_W'(STARTUP_CYCLES - 2);
            end else if (w_cnt_zero_c) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (data_valid && r_data_ready) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_STROBE;
            end
         end
         ST_STROBE: begin
            w_cnt_load  = 1'b1;
            w_cnt_value = CNT_W'(SETTLE_CYCLES - 1);
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (w_cnt_zero_c) begin
               w_report    = 1'b1;
               w_state_nxt = ST_REPORT;
            end
         end
         ST_REPORT: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase

      w_stbi_nxt  = (w_state_nxt != ST_STROBE);
      w_ready_nxt = (w_state_nxt == ST_IDLE);
      w_busy_nxt  = (w_state_nxt == ST_STROBE) || (w_state_nxt == ST_WAIT);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= ST_INIT;
         r_init_armed   <= 1'b0;
         r_x_in         <= '0;
         r_stbi         <= 1'b1;
         r_data_ready   <= 1'b0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_busy         <= 1'b0;
         r_txn_count    <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_init_armed   <= (r_state == ST_INIT);
         r_stbi         <= w_stbi_nxt;
         r_data_ready   <= w_ready_nxt;
         r_busy         <= w_busy_nxt;
         r_result_valid <= w_report;
         if (w_capture) begin
            r_x_in <= data_in;
         end
         // Out-of-range words still complete; x_out is reported as-is.
         if (w_report) begin
            r_result    <= x_out;
            r_txn_count <= r_txn_count + 8'd1;
         end
      end
   end

   assign x_in         = r_x_in;
   assign stbi         = r_stbi;
   assign data_ready   = r_data_ready;
   assign result       = r_result;
   assign result_valid = r_result_valid;
   assign busy         = r_busy;
   assign txn_count    = r_txn_count;

   a_stbi_one_cycle: assert property (@(posedge clock) disable iff (reset) !r_stbi |=> r_stbi);

endmodule

// File: tb/tb_b11_driver.sv
// Self-checking bench for b11_driver with a behavioural scrambler peer and a
// transaction-level reference model tracking expected results and counts.
module tb_b11_driver;
   import b11_pkg::*;

   localparam int unsigned STARTUP = 2;
   localparam int unsigned SETTLE  = 40;

   logic       clock = 1'b0;
   logic       reset;
   logic [5:0] data_in;
   logic       data_valid;
   logic       data_ready;
   logic [5:0] x_in;
   logic       stbi;
   logic [5:0] x_out;
   logic [5:0] result;
   logic       result_valid;
   logic       busy;
   logic [7:0] txn_count;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   b11_driver #(
      .STARTUP_CYCLES (STARTUP),
      .SETTLE_CYCLES  (SETTLE)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .data_in      (data_in),
      .data_valid   (data_valid),
      .data_ready   (data_ready),
      .x_in         (x_in),
      .stbi         (stbi),
      .x_out        (x_out),
      .result       (result),
      .result_valid (result_valid),
      .busy         (busy),
      .txn_count    (txn_count)
   );

   always #5 clock = ~clock;

   function automatic logic [5:0] scramble(input logic [5:0] x);
      return x ^ {x[3:0], x[5:4]};
   endfunction

   // Scrambler peer: captures on stbi=0, ignores words above the limit.
   logic [5:0] r_scr;
   assign x_out = r_scr;
   always @(posedge clock) begin
      if (reset)                             r_scr <= 6'h3F;
      else if (!stbi && b11_in_range(x_in))  r_scr <= scramble(x_in);
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Reference model, sampled on the falling edge.
   logic       acc_nxt = 1'b0;
   logic [5:0] acc_word, held_word;
   logic [5:0] m_scr = 6'h3F;
   logic       m_busy = 1'b0;
   int         m_wait = 0;
   logic [7:0] m_cnt = 8'd0;
   logic       prev_stbi_low = 1'b0;

   always @(negedge clock) begin
      cyc++;
      if (reset) begin
         acc_nxt       = 1'b0;
         m_busy        = 1'b0;
         m_cnt         = 8'd0;
         m_scr         = 6'h3F;
         prev_stbi_low = 1'b0;
      end else begin
         if (prev_stbi_low) chk("stbi_one_cycle", 32'(stbi), 1);
         if (acc_nxt) begin
            chk("strobe_stbi", 32'(stbi), 0);
            chk("strobe_x_in", 32'(x_in), 32'(acc_word));
            chk("strobe_busy", 32'(busy), 1);
            held_word = acc_word;
            m_busy    = 1'b1;
            m_wait    = 0;
            if (b11_in_range(acc_word)) m_scr = scramble(acc_word);
         end else begin
            chk("stbi_high", 32'(stbi), 1);
            if (m_busy) begin
               m_wait++;
               chk("x_in_held", 32'(x_in), 32'(held_word));
               chk("busy_wait", 32'(busy), 32'(!result_valid));
               if (result_valid) begin
                  chk("settle_len", 32'(m_wait), SETTLE + 1);
                  chk("result", 32'(result), 32'(m_scr));
                  m_cnt = m_cnt + 8'd1;
                  chk("txn_count", 32'(txn_count), 32'(m_cnt));
                  m_busy = 1'b0;
               end else if (m_wait > int'(SETTLE + 1)) begin
                  chk("result_timeout", 0, 1);
                  m_busy = 1'b0;
               end
            end else begin
               chk("no_spurious_rv", 32'(result_valid), 0);
            end
         end
         chk("ready_busy_excl", 32'(data_ready & busy), 0);
         prev_stbi_low = !stbi;
         acc_nxt       = data_valid && data_ready;
         acc_word      = data_in;
      end
   end

   task automatic wait_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_reset_state();
      chk("rst_x_in", 32'(x_in), 0);
      chk("rst_stbi", 32'(stbi), 1);
      chk("rst_ready", 32'(data_ready), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_rv", 32'(result_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_count", 32'(txn_count), 0);
   endtask

   task automatic startup_check();
      for (int i = 1; i < int'(STARTUP); i++) begin
         wait_cycle();
         chk("init_ready", 32'(data_ready), 0);
         chk("init_stbi", 32'(stbi), 1);
         chk("init_x_in", 32'(x_in), 0);
      end
      wait_cycle();
      chk("idle_ready", 32'(data_ready), 1);
   endtask

   task automatic reset_dut();
      reset      = 1'b1;
      data_valid = 1'b0;
      repeat (3) wait_cycle();
      chk_reset_state();
      reset = 1'b0;
      startup_check();
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 200; i++) begin
         if (data_ready) return;
         wait_cycle();
      end
      chk("ready_timeout", 0, 1);
   endtask

   task automatic wait_rv(output logic [5:0] res);
      res = 6'h00;
      for (int i = 0; i < 200; i++) begin
         wait_cycle();
         if (result_valid) begin
            res = result;
            return;
         end
      end
      chk("rv_timeout", 0, 1);
   endtask

   task automatic send(input logic [5:0] word, output logic [5:0] res);
      data_in    = word;
      data_valid = 1'b1;
      wait_ready();
      wait_cycle();
      data_valid = 1'b0;
      wait_rv(res);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] res;
      logic [5:0] w;
      int         acc;
      int         t0;
      int         t1;

      reset      = 1'b1;
      data_valid = 1'b0;
      data_in    = 6'h00;
      t0         = 0;
      t1         = 0;
      reset_dut();

      // Reset in WAIT cycle 10 aborts the transaction.
      data_in    = 6'h12;
      data_valid = 1'b1;
      wait_ready();
      wait_cycle();
      data_valid = 1'b0;
      repeat (10) wait_cycle();
      chk("abort_busy", 32'(busy), 1);
      reset = 1'b1;
      wait_cycle();
      chk_reset_state();
      reset = 1'b0;
      startup_check();
      chk("abort_count", 32'(txn_count), 0);
      chk("abort_rv", 32'(result_valid), 0);

      send(6'h3F, res);
      chk("r030_result", 32'(res), 'h3F);
      chk("r030_count", 32'(txn_count), 1);
      wait_cycle();
      chk("r030_rv_pulse", 32'(result_valid), 0);

      reset_dut();
      send(6'h00, res);
      chk("r031_first", 32'(res), 'h00);
      send(6'h1B, res);
      chk("r031_second", 32'(res), 'h00);
      chk("r031_count", 32'(txn_count), 2);

      // data_valid held high across two words.
      acc        = 0;
      data_in    = 6'h05;
      data_valid = 1'b1;
      for (int i = 0; i < 300 && acc < 2; i++) begin
         if (data_ready) begin
            acc++;
            if (acc == 1) t0 = cyc;
            else          t1 = cyc;
            wait_cycle();
            data_in = 6'h0A;
            if (acc == 2) data_valid = 1'b0;
         end else begin
            wait_cycle();
         end
      end
      chk("hold_accepts", 32'(acc), 2);
      chk("hold_gap", 32'(t1 - t0), 3 + SETTLE);
      wait_rv(res);
      chk("hold_result", 32'(res), 32'(scramble(6'h0A)));
      chk("hold_count", 32'(txn_count), 4);

      // 256 randomized transactions from reset: count wraps.
      reset_dut();
      for (int n = 1; n <= 256; n++) begin
         repeat ($urandom_range(0, 3)) wait_cycle();
         if ($urandom_range(0, 1) == 1) w = 6'($urandom_range(0, 26));
         else                           w = 6'($urandom_range(0, 63));
         send(w, res);
         if (n == 255) chk("count_255", 32'(txn_count), 255);
      end
      chk("count_wrap", 32'(txn_count), 0);

      wait_cycle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
